// File: rtl/instruction_issue_unit.sv
// instruction_issue_unit
// Holds a small program memory, sequences a PC and issues one registered
// 64-bit instruction word per cycle to the datapath controller. Every branch
// is followed by a one-cycle resolution bubble, during which the controller's
// pc_change_en decides whether the PC is redirected to the branch immediate.
// The program is written through a load port while the unit is IDLE or HALT.
//
// Optional feature macro: ISSUE_STATS_EN
//   When defined, adds saturating issued_count_o / taken_count_o counters.
module instruction_issue_unit #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [63:0]       load_data,
  output logic              load_ready,
  input  logic              start,
  input  logic              pc_change_en,
  output logic [63:0]       instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
`ifdef ISSUE_STATS_EN
  output logic [31:0]       issued_count_o,
  output logic [31:0]       taken_count_o,
`endif
  output logic              busy,
  output logic              halted
);

  localparam logic [63:0] NOP_WORD  = 64'h0B00_0000_0000_0000;
  localparam logic [63:0] HALT_WORD = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [1:0]  COND_NONE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_BR_WAIT,
    S_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   br_target_q, br_target_d;
  logic [63:0]         instr_q, instr_d;
  logic                valid_q, valid_d;
  logic [63:0]         mem [DEPTH];
  logic [63:0]         fetch_word;
  logic                load_accept;

  // Loads are only honoured while the sequencer is not fetching.
  assign load_ready  = (state_q == S_IDLE) || (state_q == S_HALT);
  assign load_accept = load_en && load_ready;

  // Combinational read of the slot addressed by the PC register.
  assign fetch_word = mem[pc_q];

  // Program memory write port.
  // NOTE: the storage array has no reset branch on purpose; clearing it would
  // turn a plain RAM into a register file and wipe the program on every reset.
  always_ff @(posedge clk) begin
    if (load_accept) begin
      mem[load_addr] <= load_data;
    end
  end

  // State, PC, branch target and issued word registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from the same edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      br_target_q <= '0;
      instr_q     <= NOP_WORD;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      br_target_q <= br_target_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
    end
  end

  // Next-state and next-issue logic of the fetch sequencer.
  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    br_target_d = br_target_q;
    instr_d     = NOP_WORD;
    valid_d     = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_RUN: begin
        if (fetch_word == HALT_WORD) begin
          // PC stays on the HALT word's slot.
          state_d = S_HALT;
        end else begin
          instr_d = fetch_word;
          valid_d = 1'b1;
          pc_d    = pc_q + 1'b1; // wraps naturally at DEPTH-1
          if (fetch_word[57:56] != COND_NONE) begin
            state_d     = S_BR_WAIT;
            // Only the low ADDR_W bits of the immediate address the memory.
            br_target_d = fetch_word[ADDR_W-1:0];
          end
        end
      end
      S_BR_WAIT: begin
        // Bubble cycle while the controller resolves the branch.
        state_d = S_RUN;
        if (pc_change_en) begin
          pc_d = br_target_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef ISSUE_STATS_EN
  logic [31:0] issued_q, taken_q;
  logic        start_accept;

  assign start_accept = start && load_ready;

  // Saturating issue / taken-branch counters, cleared by each accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      taken_q  <= '0;
    end else if (start_accept) begin
      issued_q <= '0;
      taken_q  <= '0;
    end else begin
      if (valid_d && (issued_q != 32'hFFFF_FFFF)) begin
        issued_q <= issued_q + 32'd1;
      end
      if ((state_q == S_BR_WAIT) && pc_change_en && (taken_q != 32'hFFFF_FFFF)) begin
        taken_q <= taken_q + 32'd1;
      end
    end
  end

  assign issued_count_o = issued_q;
  assign taken_count_o  = taken_q;
`endif

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = (state_q == S_RUN) || (state_q == S_BR_WAIT);
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instruction_issue_unit.sv
// Self-checking bench for instruction_issue_unit: a table of per-cycle
// stimulus/expected records followed by hand-written wrap and reset sequences.
module tb_instruction_issue_unit;

  localparam logic [63:0] NOP  = 64'h0B00_0000_0000_0000;
  localparam logic [63:0] HLT  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] WA   = 64'h4B11_2233_0000_00AA;
  localparam logic [63:0] WB   = 64'h8B44_5566_0000_00BB;
  localparam logic [63:0] BR   = 64'h0012_3456_0000_0145; // cond 00, imm low bits = 5
  localparam logic [63:0] M1   = 64'h2B00_0000_0000_0011;
  localparam logic [63:0] M5   = 64'h1B00_0000_0000_0055;
  localparam logic [63:0] WX   = 64'h7B00_0000_DEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0;
  logic [5:0]  load_addr = '0;
  logic [63:0] load_data = '0;
  logic        load_ready;
  logic        start = 1'b0;
  logic        pc_change_en = 1'b0;
  logic [63:0] instruction;
  logic        instr_valid;
  logic [5:0]  pc;
  logic        busy;
  logic        halted;
`ifdef ISSUE_STATS_EN
  logic [31:0] issued_count_o;
  logic [31:0] taken_count_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  instruction_issue_unit #(.DEPTH(64)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .start        (start),
    .pc_change_en (pc_change_en),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .pc           (pc),
`ifdef ISSUE_STATS_EN
    .issued_count_o (issued_count_o),
    .taken_count_o  (taken_count_o),
`endif
    .busy         (busy),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [5:0]  addr;
    logic [63:0] data;
    logic        st;
    logic        pce;
    logic [63:0] e_instr;
    logic        e_valid;
    logic [5:0]  e_pc;
    logic        e_busy;
    logic        e_halt;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ld, logic [5:0] a, logic [63:0] d, logic st,
                              logic pce, logic [63:0] ei, logic ev, logic [5:0] ep,
                              logic eb, logic eh, logic er);
    vec_t v;
    v.ld = ld; v.addr = a; v.data = d; v.st = st; v.pce = pce;
    v.e_instr = ei; v.e_valid = ev; v.e_pc = ep;
    v.e_busy = eb; v.e_halt = eh; v.e_rdy = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [63:0] ei, input logic ev,
                            input logic [5:0] ep, input logic eb, input logic eh,
                            input logic er);
    check({tag, ".instruction"}, instruction, ei);
    check({tag, ".instr_valid"}, {63'd0, instr_valid}, {63'd0, ev});
    check({tag, ".pc"},          {58'd0, pc},          {58'd0, ep});
    check({tag, ".busy"},        {63'd0, busy},        {63'd0, eb});
    check({tag, ".halted"},      {63'd0, halted},      {63'd0, eh});
    check({tag, ".load_ready"},  {63'd0, load_ready},  {63'd0, er});
  endtask

  function automatic logic [63:0] wrap_word(int i);
    logic [63:0] w;
    w = 64'h0F00_0000_0000_0000 | 64'(i);
    return w;
  endfunction

  // Hard stop in case the run never reaches its summary.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic program, halt, loads in HALT, taken / not-taken branch,
    // loads and start ignored while busy.
    vecs.push_back(mk(1, 0, WA,  0, 0, NOP, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, WB,  0, 0, NOP, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 2, HLT, 0, 0, NOP, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,   1, 0, NOP, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, WA,  1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, WB,  1, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, NOP, 0, 2, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, NOP, 0, 2, 0, 1, 1));
    vecs.push_back(mk(1, 0, BR,  0, 0, NOP, 0, 2, 0, 1, 1));
    vecs.push_back(mk(1, 1, M1,  0, 0, NOP, 0, 2, 0, 1, 1));
    vecs.push_back(mk(1, 5, M5,  0, 0, NOP, 0, 2, 0, 1, 1));
    vecs.push_back(mk(1, 6, HLT, 0, 0, NOP, 0, 2, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,   1, 0, NOP, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, BR,  1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 1, NOP, 0, 5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, M5,  1, 6, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, NOP, 0, 6, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,   1, 0, NOP, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 1, BR,  1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, NOP, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, M1,  1, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, NOP, 0, 2, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,   1, 0, NOP, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, WX,  1, 0, BR,  1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, WX,  0, 0, NOP, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, M1,  1, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, NOP, 0, 2, 0, 1, 1));

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", NOP, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs("post_reset", NOP, 0, 0, 0, 0, 1);

    // Table: drive one row, clock, compare registered outputs.
    foreach (vecs[i]) begin
      load_en      = vecs[i].ld;
      load_addr    = vecs[i].addr;
      load_data    = vecs[i].data;
      start        = vecs[i].st;
      pc_change_en = vecs[i].pce;
      @(posedge clk);
      #1;
      check_outs($sformatf("row%0d", i), vecs[i].e_instr, vecs[i].e_valid,
                 vecs[i].e_pc, vecs[i].e_busy, vecs[i].e_halt, vecs[i].e_rdy);
    end
    load_en = 1'b0; start = 1'b0; pc_change_en = 1'b0;

    // PC wrap: fill every slot with non-branch words and run past the end.
    for (int i = 0; i < 64; i++) begin
      load_en   = 1'b1;
      load_addr = 6'(i);
      load_data = wrap_word(i);
      @(posedge clk);
      #1;
    end
    load_en = 1'b0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_outs("wrap_start", NOP, 0, 0, 1, 0, 0);
    for (int k = 0; k < 66; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("wrap%0d.instruction", k), instruction, wrap_word(k % 64));
      check($sformatf("wrap%0d.pc", k), {58'd0, pc}, 64'((k + 1) % 64));
    end
`ifdef ISSUE_STATS_EN
    check("stats.issued_after_wrap", {32'd0, issued_count_o}, 64'd66);
    check("stats.taken_after_wrap",  {32'd0, taken_count_o},  64'd0);
`endif

    // Asynchronous reset mid-RUN, then restart with the retained program.
    rst_n = 1'b0;
    #1;
    check_outs("midrun_reset", NOP, 0, 0, 0, 0, 1);
`ifdef ISSUE_STATS_EN
    check("stats.issued_reset", {32'd0, issued_count_o}, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_outs("restart", NOP, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    check_outs("restart_w0", wrap_word(0), 1, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    check_outs("restart_w1", wrap_word(1), 1, 2, 1, 0, 0);
`ifdef ISSUE_STATS_EN
    check("stats.issued_restart", {32'd0, issued_count_o}, 64'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_issue_unit.md
Name: instruction_issue_unit

Overview:
Instruction-side partner of the datapath controller. It holds a small program memory, sequences a PC, and drives one 64-bit instruction word per cycle onto the controller's instruction input. It inserts a resolution bubble after every branch and redirects the PC when the controller returns its PC-change enable. The program is loaded through a simple write port while the unit is idle or halted.

Parameters:
DEPTH, 64, number of 64-bit instruction slots (power of two, ≥4)
ADDR_W, $clog2(DEPTH), PC / load address width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load_en  input  1  write load_data into slot load_addr this cycle
load_addr  input  ADDR_W  program slot address
load_data  input  64  instruction word to store
load_ready  output  1  high when a load is accepted (IDLE or HALT)
start  input  1  one-cycle pulse; begin execution at PC 0
pc_change_en  input  1  branch-taken result from the datapath controller
instruction  output  64  issued instruction word (registered)
instr_valid  output  1  instruction is a real program word this cycle
pc  output  ADDR_W  address of the next word to fetch
busy  output  1  state is RUN or BR_WAIT
halted  output  1  state is HALT

Behaviour:
- Field map of an issued word:
  - [63:62] memory/RF op class
  - [61:60] source select
  - [59:58] computation
  - [57:56] branch condition; 11 means not a branch
  - [55:48] target
  - [47:40] source A
  - [39:32] source B
  - [31:0] immediate
- NOP = 64'h0B00_0000_0000_0000 (compute 10, condition 11; no enables asserted). HALT word = 64'hFFFF_FFFF_FFFF_FFFF.
- Reset (async, rst_n=0) values:
  - state IDLE, pc=0
  - instruction=NOP, instr_valid=0
  - busy=0, halted=0, load_ready=1
  - program memory contents undefined (not cleared)
- IDLE:
  - load_en writes mem[load_addr] at the clock edge.
  - start moves to RUN with pc=0.
  - If load_en and start are high together, the write completes and the move to RUN still happens.
- RUN, each cycle with w = mem[pc]:
  - w == HALT: instruction=NOP, instr_valid=0, go to HALT; pc holds the HALT word's address.
  - w[57:56] != 11 (branch): instruction=w, instr_valid=1, pc<=pc+1, go to BR_WAIT.
  - Otherwise: instruction=w, instr_valid=1, pc<=pc+1.
  - pc wraps from DEPTH-1 to 0 with no flag.
- BR_WAIT (exactly one cycle):
  - Drives instruction=NOP, instr_valid=0.
  - Samples pc_change_en: if 1, pc <= branch_word[ADDR_W-1:0], where branch_word is the registered immediate of the branch; if 0, pc is unchanged.
  - Returns to RUN.
  - Branch-to-self is legal.
  - Immediate bits above ADDR_W are ignored.
- HALT:
  - instruction=NOP, instr_valid=0, halted=1.
  - Loads are accepted.
  - start restarts at pc=0.
- load_en in RUN or BR_WAIT is ignored (no write); load_ready=0 in those states.
- start in RUN or BR_WAIT is ignored.
- pc_change_en outside BR_WAIT is ignored.
- Latency: a word fetched at edge N appears on instruction after edge N (registered). Throughput is one word per cycle, minus one bubble per branch.
- Memory read is combinational from the pc register; output is registered.
- Reset asserted mid-RUN returns immediately to the reset values; program memory contents are retained.

Optional Feature:
ISSUE_STATS_EN
- Defined: adds outputs issued_count[31:0] and taken_count[31:0].
  - issued_count increments for each instr_valid=1 cycle.
  - taken_count increments in each BR_WAIT cycle where pc_change_en=1.
  - Both saturate at 32'hFFFF_FFFF, clear on reset, and clear on each accepted start.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then load mem[0..2] = {A, B, HALT} with A, B non-branch; pulse start -> instruction=A then B with instr_valid=1, then NOP with instr_valid=0 and halted=1; pc=2.
- mem[0] = branch word (bits[57:56]=00, imm=5); start; drive pc_change_en=1 during BR_WAIT -> cycle 1 issues the branch, cycle 2 is a NOP bubble, cycle 3 issues mem[5].
- Same program with pc_change_en=0 during BR_WAIT -> after the bubble, mem[1] is issued.
- DEPTH=4, all words non-branch, no HALT -> issue order 0,1,2,3,0,1; pc wraps with no stall.
- load_en=1 with addr 1 while busy -> mem[1] unchanged; load_ready=0; a later issue of slot 1 shows the original word.
- Assert rst_n=0 mid-RUN for 1 cycle -> instruction=NOP, instr_valid=0, state IDLE, pc=0; a restart with start re-issues the previously loaded program unchanged.
